// File: rtl/host_input_pkg.sv
// Shared definitions for the host-input pipeline: EtherType constants,
// dispatcher state encoding and beat-format constants.
package host_input_pkg;

  localparam logic [15:0] ETH_PTP    = 16'h98F7;
  localparam logic [15:0] ETH_NMAC   = 16'h1662;

  localparam int MARK_BIT   = 8;
  localparam int BYTE_W     = 8;
  localparam int BEAT_W     = BYTE_W + 1;
  localparam int BEAT_CNT_W = 12;

  typedef enum logic [2:0] {
    IDLE_S  = 3'd0,
    FWD_S   = 3'd1,
    CTRL_S  = 3'd2,
    DISC_S  = 3'd3,
    TRUNC_S = 3'd4
  } state_e;

  function automatic logic is_ctrl_type(input logic [15:0] eth,
                                        input logic [15:0] ptp,
                                        input logic [15:0] nmac);
    return (eth == ptp) || (eth == nmac);
  endfunction

endpackage

// File: rtl/frame_dispatch_cnt.sv
// Wrapping statistics counter with synchronous clear; clear beats increment.
module frame_dispatch_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] ov_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)      cnt_d = '0;
    else if (i_inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign ov_cnt = cnt_q;

endmodule

// File: rtl/frame_dispatch.sv
// Steers host-input frames to the forwarding path, the control path or
// the bin, with a per-frame length limit and per-class counters.
//
//   state   | meaning
//   IDLE_S  | waiting for a head beat; non-head beats are orphans
//   FWD_S   | passing a frame on the forwarding path
//   CTRL_S  | passing a frame on the control path
//   DISC_S  | dropping a missed frame until its tail
//   TRUNC_S | dropping the overlong remainder until its tail
module frame_dispatch
  import host_input_pkg::*;
#(
  parameter logic [15:0] PTP_ETHTYPE  = ETH_PTP,
  parameter logic [15:0] NMAC_ETHTYPE = ETH_NMAC,
  parameter int          MAX_BEATS    = 1522,
  parameter int          CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       iv_eth_type,
  input  logic [47:0]       iv_tsntag,
  input  logic              i_hit,
  input  logic              i_replication_flag,
  input  logic              i_standardpkt_tsnpkt_flag,
  input  logic [BEAT_W-1:0] iv_data,
  input  logic              i_data_wr,
  input  logic              i_cnt_clear,
  output logic [BEAT_W-1:0] ov_fwd_data,
  output logic              o_fwd_data_wr,
  output logic [47:0]       ov_fwd_tsntag,
  output logic              o_fwd_replication_flag,
  output logic              o_fwd_standardpkt_tsnpkt_flag,
  output logic [BEAT_W-1:0] ov_ctrl_data,
  output logic              o_ctrl_data_wr,
  output logic [15:0]       ov_ctrl_eth_type,
  output logic [CNT_W-1:0]  ov_fwd_pkt_cnt,
  output logic [CNT_W-1:0]  ov_ctrl_pkt_cnt,
  output logic [CNT_W-1:0]  ov_discard_pkt_cnt,
  output logic [CNT_W-1:0]  ov_trunc_pkt_cnt
);

  localparam logic [BEAT_CNT_W-1:0] MAX_LIM = BEAT_CNT_W'(MAX_BEATS);

  state_e                  state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d, beat_nxt;
  logic [BEAT_W-1:0]       fwd_data_q, fwd_data_d, ctrl_data_q, ctrl_data_d, beat_out;
  logic                    fwd_wr_q, fwd_wr_d, ctrl_wr_q, ctrl_wr_d;
  logic [47:0]             tag_q, tag_d;
  logic                    repl_q, repl_d, std_q, std_d;
  logic [15:0]             eth_q, eth_d;
  logic                    is_mark, at_limit;
  logic                    inc_fwd, inc_ctrl, inc_disc, inc_trunc;

  assign is_mark  = i_data_wr && iv_data[MARK_BIT];
  assign beat_nxt = beat_q + BEAT_CNT_W'(1);
  assign at_limit = (beat_nxt == MAX_LIM);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    fwd_data_d  = '0;
    fwd_wr_d    = 1'b0;
    ctrl_data_d = '0;
    ctrl_wr_d   = 1'b0;
    tag_d       = tag_q;
    repl_d      = repl_q;
    std_d       = std_q;
    eth_d       = eth_q;
    beat_out    = iv_data;
    inc_fwd     = 1'b0;
    inc_ctrl    = 1'b0;
    inc_disc    = 1'b0;
    inc_trunc   = 1'b0;

    case (state_q)
      IDLE_S: begin
        if (is_mark) begin
          beat_d = BEAT_CNT_W'(1);
          if (is_ctrl_type(iv_eth_type, PTP_ETHTYPE, NMAC_ETHTYPE)) begin
            state_d     = CTRL_S;
            eth_d       = iv_eth_type;
            ctrl_wr_d   = 1'b1;
            ctrl_data_d = iv_data;
          end else if (i_hit) begin
            state_d    = FWD_S;
            tag_d      = iv_tsntag;
            repl_d     = i_replication_flag;
            std_d      = i_standardpkt_tsnpkt_flag;
            fwd_wr_d   = 1'b1;
            fwd_data_d = iv_data;
          end else begin
            state_d = DISC_S;
          end
        end
      end
      FWD_S, CTRL_S: begin
        if (i_data_wr) begin
          beat_d = beat_nxt;
          // A genuine tail wins over the limit, so a frame of exactly MAX_BEATS is not truncated.
          if (iv_data[MARK_BIT]) begin
            state_d = IDLE_S;
          end else if (at_limit) begin
            beat_out[MARK_BIT] = 1'b1;
            inc_trunc          = 1'b1;
            state_d            = TRUNC_S;
          end
          if (state_q == FWD_S) begin
            fwd_wr_d   = 1'b1;
            fwd_data_d = beat_out;
            inc_fwd    = iv_data[MARK_BIT] || at_limit;
          end else begin
            ctrl_wr_d   = 1'b1;
            ctrl_data_d = beat_out;
            inc_ctrl    = iv_data[MARK_BIT] || at_limit;
          end
        end
      end
      DISC_S: begin
        if (is_mark) begin
          inc_disc = 1'b1;
          state_d  = IDLE_S;
        end
      end
      TRUNC_S: begin
        if (is_mark) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE_S;
      beat_q      <= '0;
      fwd_data_q  <= '0;
      fwd_wr_q    <= 1'b0;
      ctrl_data_q <= '0;
      ctrl_wr_q   <= 1'b0;
      tag_q       <= '0;
      repl_q      <= 1'b0;
      std_q       <= 1'b0;
      eth_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      fwd_data_q  <= fwd_data_d;
      fwd_wr_q    <= fwd_wr_d;
      ctrl_data_q <= ctrl_data_d;
      ctrl_wr_q   <= ctrl_wr_d;
      tag_q       <= tag_d;
      repl_q      <= repl_d;
      std_q       <= std_d;
      eth_q       <= eth_d;
    end
  end

  assign ov_fwd_data                   = fwd_data_q;
  assign o_fwd_data_wr                 = fwd_wr_q;
  assign ov_fwd_tsntag                 = tag_q;
  assign o_fwd_replication_flag        = repl_q;
  assign o_fwd_standardpkt_tsnpkt_flag = std_q;
  assign ov_ctrl_data                  = ctrl_data_q;
  assign o_ctrl_data_wr                = ctrl_wr_q;
  assign ov_ctrl_eth_type              = eth_q;

  frame_dispatch_cnt #(.CNT_W(CNT_W)) u_cnt_fwd (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_cnt_clear), .i_inc(inc_fwd), .ov_cnt(ov_fwd_pkt_cnt)
  );
  frame_dispatch_cnt #(.CNT_W(CNT_W)) u_cnt_ctrl (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_cnt_clear), .i_inc(inc_ctrl), .ov_cnt(ov_ctrl_pkt_cnt)
  );
  frame_dispatch_cnt #(.CNT_W(CNT_W)) u_cnt_disc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_cnt_clear), .i_inc(inc_disc), .ov_cnt(ov_discard_pkt_cnt)
  );
  frame_dispatch_cnt #(.CNT_W(CNT_W)) u_cnt_trunc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_cnt_clear), .i_inc(inc_trunc), .ov_cnt(ov_trunc_pkt_cnt)
  );

endmodule

// File: tb/tb_frame_dispatch.sv
// Bench for frame_dispatch: two instances (default limit and a 64-beat limit)
// share one stimulus stream and are checked every cycle against a frame-level model.
module tb_frame_dispatch;

  localparam int NI = 2;
  localparam int K_IDLE = 0, K_FWD = 1, K_CTRL = 2, K_DISC = 3, K_DROP = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] iv_eth_type = '0;
  logic [47:0] iv_tsntag = '0;
  logic        i_hit = 1'b0, i_replication_flag = 1'b0, i_standardpkt_tsnpkt_flag = 1'b0;
  logic [8:0]  iv_data = '0;
  logic        i_data_wr = 1'b0, i_cnt_clear = 1'b0;

  logic [8:0]  fwd_data[NI];
  logic        fwd_wr[NI];
  logic [47:0] tag[NI];
  logic        repl[NI], stdf[NI];
  logic [8:0]  ctrl_data[NI];
  logic        ctrl_wr[NI];
  logic [15:0] eth_o[NI];
  logic [31:0] c_fwd[NI], c_ctrl[NI], c_disc[NI], c_trunc[NI];

  always #5 i_clk = ~i_clk;

  frame_dispatch dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_eth_type(iv_eth_type), .iv_tsntag(iv_tsntag),
    .i_hit(i_hit), .i_replication_flag(i_replication_flag),
    .i_standardpkt_tsnpkt_flag(i_standardpkt_tsnpkt_flag), .iv_data(iv_data),
    .i_data_wr(i_data_wr), .i_cnt_clear(i_cnt_clear),
    .ov_fwd_data(fwd_data[0]), .o_fwd_data_wr(fwd_wr[0]), .ov_fwd_tsntag(tag[0]),
    .o_fwd_replication_flag(repl[0]), .o_fwd_standardpkt_tsnpkt_flag(stdf[0]),
    .ov_ctrl_data(ctrl_data[0]), .o_ctrl_data_wr(ctrl_wr[0]), .ov_ctrl_eth_type(eth_o[0]),
    .ov_fwd_pkt_cnt(c_fwd[0]), .ov_ctrl_pkt_cnt(c_ctrl[0]),
    .ov_discard_pkt_cnt(c_disc[0]), .ov_trunc_pkt_cnt(c_trunc[0])
  );

  frame_dispatch #(.MAX_BEATS(64)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_eth_type(iv_eth_type), .iv_tsntag(iv_tsntag),
    .i_hit(i_hit), .i_replication_flag(i_replication_flag),
    .i_standardpkt_tsnpkt_flag(i_standardpkt_tsnpkt_flag), .iv_data(iv_data),
    .i_data_wr(i_data_wr), .i_cnt_clear(i_cnt_clear),
    .ov_fwd_data(fwd_data[1]), .o_fwd_data_wr(fwd_wr[1]), .ov_fwd_tsntag(tag[1]),
    .o_fwd_replication_flag(repl[1]), .o_fwd_standardpkt_tsnpkt_flag(stdf[1]),
    .ov_ctrl_data(ctrl_data[1]), .o_ctrl_data_wr(ctrl_wr[1]), .ov_ctrl_eth_type(eth_o[1]),
    .ov_fwd_pkt_cnt(c_fwd[1]), .ov_ctrl_pkt_cnt(c_ctrl[1]),
    .ov_discard_pkt_cnt(c_disc[1]), .ov_trunc_pkt_cnt(c_trunc[1])
  );

  // ---------------- reference model ----------------
  int          m_kind[NI], m_n[NI];
  logic [8:0]  m_fwd_data[NI], m_ctrl_data[NI];
  logic        m_fwd_wr[NI], m_ctrl_wr[NI], m_repl[NI], m_std[NI];
  logic [47:0] m_tag[NI];
  logic [15:0] m_eth[NI];
  logic [31:0] m_fwd[NI], m_ctrl[NI], m_disc[NI], m_trunc[NI];

  function automatic int max_of(input int k);
    return (k == 0) ? 1522 : 64;
  endfunction

  task automatic model_step(input int k);
    bit fi, ci, di, ti, was_fwd;
    logic [8:0] b;
    fi = 0; ci = 0; di = 0; ti = 0;
    if (!i_rst_n) begin
      m_kind[k] = K_IDLE; m_n[k] = 0;
      m_fwd_data[k] = '0; m_ctrl_data[k] = '0; m_fwd_wr[k] = 0; m_ctrl_wr[k] = 0;
      m_repl[k] = 0; m_std[k] = 0; m_tag[k] = '0; m_eth[k] = '0;
      m_fwd[k] = '0; m_ctrl[k] = '0; m_disc[k] = '0; m_trunc[k] = '0;
      return;
    end
    m_fwd_wr[k] = 0; m_fwd_data[k] = '0; m_ctrl_wr[k] = 0; m_ctrl_data[k] = '0;
    if (i_data_wr) begin
      b = iv_data;
      if (m_kind[k] == K_IDLE) begin
        if (b[8]) begin
          m_n[k] = 1;
          if (iv_eth_type == 16'h98F7 || iv_eth_type == 16'h1662) begin
            m_kind[k] = K_CTRL; m_eth[k] = iv_eth_type;
            m_ctrl_wr[k] = 1; m_ctrl_data[k] = b;
          end else if (i_hit) begin
            m_kind[k] = K_FWD; m_tag[k] = iv_tsntag;
            m_repl[k] = i_replication_flag; m_std[k] = i_standardpkt_tsnpkt_flag;
            m_fwd_wr[k] = 1; m_fwd_data[k] = b;
          end else begin
            m_kind[k] = K_DISC;
          end
        end
      end else if (m_kind[k] == K_FWD || m_kind[k] == K_CTRL) begin
        was_fwd = (m_kind[k] == K_FWD);
        m_n[k]++;
        if (b[8]) begin
          m_kind[k] = K_IDLE;
          if (was_fwd) fi = 1; else ci = 1;
        end else if (m_n[k] == max_of(k)) begin
          b[8] = 1'b1; ti = 1; m_kind[k] = K_DROP;
          if (was_fwd) fi = 1; else ci = 1;
        end
        if (was_fwd) begin m_fwd_wr[k] = 1; m_fwd_data[k] = b; end
        else begin m_ctrl_wr[k] = 1; m_ctrl_data[k] = b; end
      end else if (b[8]) begin
        if (m_kind[k] == K_DISC) di = 1;
        m_kind[k] = K_IDLE;
      end
    end
    if (i_cnt_clear) begin
      m_fwd[k] = '0; m_ctrl[k] = '0; m_disc[k] = '0; m_trunc[k] = '0;
    end else begin
      m_fwd[k] += 32'(fi); m_ctrl[k] += 32'(ci); m_disc[k] += 32'(di); m_trunc[k] += 32'(ti);
    end
  endtask

  always @(posedge i_clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", nm, k, $time, a, e);
    end
  endtask

  int n_fwd[NI], n_fwd_mark[NI], n_ctrl[NI], n_ctrl_mark[NI];

  always @(negedge i_clk) begin
    for (int k = 0; k < NI; k++) begin
      chk("fwd_wr", k, 64'(fwd_wr[k]), 64'(m_fwd_wr[k]));
      chk("fwd_data", k, 64'(fwd_data[k]), 64'(m_fwd_data[k]));
      chk("ctrl_wr", k, 64'(ctrl_wr[k]), 64'(m_ctrl_wr[k]));
      chk("ctrl_data", k, 64'(ctrl_data[k]), 64'(m_ctrl_data[k]));
      chk("fwd_tag", k, 64'(tag[k]), 64'(m_tag[k]));
      chk("fwd_repl", k, 64'(repl[k]), 64'(m_repl[k]));
      chk("fwd_std", k, 64'(stdf[k]), 64'(m_std[k]));
      chk("ctrl_eth", k, 64'(eth_o[k]), 64'(m_eth[k]));
      chk("cnt_fwd", k, 64'(c_fwd[k]), 64'(m_fwd[k]));
      chk("cnt_ctrl", k, 64'(c_ctrl[k]), 64'(m_ctrl[k]));
      chk("cnt_disc", k, 64'(c_disc[k]), 64'(m_disc[k]));
      chk("cnt_trunc", k, 64'(c_trunc[k]), 64'(m_trunc[k]));
      if (fwd_wr[k] === 1'b1) begin n_fwd[k]++; if (fwd_data[k][8]) n_fwd_mark[k]++; end
      if (ctrl_wr[k] === 1'b1) begin n_ctrl[k]++; if (ctrl_data[k][8]) n_ctrl_mark[k]++; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit wr, input logic [8:0] d, input bit clr);
    @(posedge i_clk); #1;
    i_data_wr = wr; iv_data = d; i_cnt_clear = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 9'($urandom), 1'b0);
  endtask

  task automatic zero_mon();
    for (int k = 0; k < NI; k++) begin
      n_fwd[k] = 0; n_fwd_mark[k] = 0; n_ctrl[k] = 0; n_ctrl_mark[k] = 0;
    end
  endtask

  task automatic send_frame(input int len, input logic [15:0] eth, input bit hit,
                            input logic [47:0] t, input bit rf, input bit sf,
                            input int gap_pct, input bit three_gaps,
                            input bit no_tail, input bit clr_tail);
    bit mark;
    for (int i = 0; i < len; i++) begin
      if (three_gaps && (i == 5 || i == 10 || i == 15)) idle(1);
      if (gap_pct > 0 && i > 0 && $urandom_range(99) < gap_pct) idle(1);
      mark = (i == 0) || (i == len - 1 && !no_tail);
      @(posedge i_clk); #1;
      if (i == 0) begin
        iv_eth_type = eth; iv_tsntag = t; i_hit = hit;
        i_replication_flag = rf; i_standardpkt_tsnpkt_flag = sf;
      end else begin
        iv_eth_type = 16'($urandom); iv_tsntag = {16'($urandom), 32'($urandom)};
        i_hit = 1'($urandom); i_replication_flag = 1'($urandom);
        i_standardpkt_tsnpkt_flag = 1'($urandom);
      end
      i_data_wr = 1'b1;
      iv_data = {mark, 8'($urandom)};
      i_cnt_clear = clr_tail && (i == len - 1);
    end
  endtask

  task automatic settle();
    idle(2);
    @(negedge i_clk);
  endtask

  initial begin
    logic [15:0] e;
    zero_mon();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_fwd_wr", k, 64'(fwd_wr[k]), 64'd0);
      chk("rst_cnt_fwd", k, 64'(c_fwd[k]), 64'd0);
      chk("rst_tag", k, 64'(tag[k]), 64'd0);
    end
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    idle(2);

    // hit frame, 64 beats
    cyc(1'b0, 9'd0, 1'b1); zero_mon();
    send_frame(64, 16'h0800, 1'b1, 48'h0123_4567_89AB, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t1_tag", k, 64'(tag[k]), 64'h0123_4567_89AB);
      chk("t1_fwd_cnt", k, 64'(c_fwd[k]), 64'd1);
      chk("t1_fwd_beats", k, 64'(n_fwd[k]), 64'd64);
      chk("t1_fwd_marks", k, 64'(n_fwd_mark[k]), 64'd2);
      chk("t1_ctrl_beats", k, 64'(n_ctrl[k]), 64'd0);
      chk("t1_trunc", k, 64'(c_trunc[k]), 64'd0);
    end

    // PTP miss, 80 beats (inst1 truncates at 64)
    cyc(1'b0, 9'd0, 1'b1); zero_mon();
    send_frame(80, 16'h98F7, 1'b0, 48'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t2_eth", k, 64'(eth_o[k]), 64'h98F7);
      chk("t2_ctrl_cnt", k, 64'(c_ctrl[k]), 64'd1);
      chk("t2_ctrl_beats", k, 64'(n_ctrl[k]), (k == 0) ? 64'd80 : 64'd64);
      chk("t2_ctrl_marks", k, 64'(n_ctrl_mark[k]), 64'd2);
      chk("t2_trunc", k, 64'(c_trunc[k]), (k == 0) ? 64'd0 : 64'd1);
      chk("t2_tag_held", k, 64'(tag[k]), 64'h0123_4567_89AB);
    end

    // miss frame, discarded
    cyc(1'b0, 9'd0, 1'b1); zero_mon();
    send_frame(64, 16'h0800, 1'b0, 48'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t3_disc", k, 64'(c_disc[k]), 64'd1);
      chk("t3_beats", k, 64'(n_fwd[k] + n_ctrl[k]), 64'd0);
    end

    // 100-beat hit frame, then a normal one
    cyc(1'b0, 9'd0, 1'b1); zero_mon();
    send_frame(100, 16'h0800, 1'b1, 48'hA5A5_0000_5A5A, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t4_fwd_beats", k, 64'(n_fwd[k]), (k == 0) ? 64'd100 : 64'd64);
      chk("t4_fwd_cnt", k, 64'(c_fwd[k]), 64'd1);
      chk("t4_trunc", k, 64'(c_trunc[k]), (k == 0) ? 64'd0 : 64'd1);
    end
    send_frame(64, 16'h0800, 1'b1, 48'h1111_2222_3333, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t4b_fwd_cnt", k, 64'(c_fwd[k]), 64'd2);
      chk("t4b_fwd_beats", k, 64'(n_fwd[k]), (k == 0) ? 64'd164 : 64'd128);
      chk("t4b_marks", k, 64'(n_fwd_mark[k]), 64'd4);
    end

    // back-to-back fwd (with three gaps) then ctrl
    cyc(1'b0, 9'd0, 1'b1); zero_mon();
    send_frame(20, 16'h0800, 1'b1, 48'hBEEF_0000_CAFE, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    send_frame(10, 16'h1662, 1'b1, 48'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t5_fwd_cnt", k, 64'(c_fwd[k]), 64'd1);
      chk("t5_ctrl_cnt", k, 64'(c_ctrl[k]), 64'd1);
      chk("t5_fwd_beats", k, 64'(n_fwd[k]), 64'd20);
      chk("t5_ctrl_beats", k, 64'(n_ctrl[k]), 64'd10);
      chk("t5_eth", k, 64'(eth_o[k]), 64'h1662);
    end

    // reset mid-frame, orphans, then clear colliding with a tail
    send_frame(12, 16'h0800, 1'b1, 48'h7777, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    @(posedge i_clk); #1; i_rst_n = 1'b0; i_data_wr = 1'b0;
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    zero_mon();
    repeat (20) cyc(1'b1, {1'b0, 8'($urandom)}, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t6_orphan_beats", k, 64'(n_fwd[k] + n_ctrl[k]), 64'd0);
      chk("t6_cnt_sum", k, 64'(c_fwd[k]) + 64'(c_ctrl[k]) + 64'(c_disc[k]), 64'd0);
    end
    send_frame(10, 16'h98F7, 1'b0, 48'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < NI; k++) chk("t6_ctrl_after", k, 64'(c_ctrl[k]), 64'd1);
    send_frame(10, 16'h0800, 1'b1, 48'h9999, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    settle();
    for (int k = 0; k < NI; k++) begin
      chk("t6_clr_fwd", k, 64'(c_fwd[k]), 64'd0);
      chk("t6_clr_ctrl", k, 64'(c_ctrl[k]), 64'd0);
    end

    // randomized traffic
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(3))
        0: e = 16'h98F7;
        1: e = 16'h1662;
        2: e = 16'h0800;
        default: e = 16'($urandom);
      endcase
      if ($urandom_range(7) == 0) repeat ($urandom_range(1, 4)) cyc(1'b1, {1'b0, 8'($urandom)}, 1'b0);
      send_frame($urandom_range(2, 110), e, 1'($urandom), {16'($urandom), 32'($urandom)},
                 1'($urandom), 1'($urandom), 20, 1'b0, 1'b0, ($urandom_range(9) == 0));
      idle($urandom_range(0, 2));
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
